// File: rtl/led_pattern_seq.sv
// led_pattern_seq
// Steps a selectable LED pattern once per rising edge of a slow divided-clock
// level ("tick") that is asynchronous to clk.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   tick       divided-clock level, asynchronous to clk; each rising edge is one step
//   S          pause/blank: freezes the pattern and forces L to zero
//   mode       pattern select: 0 binary, 1 walk, 2 bounce, 3 blink
//   L          LED drive (combinationally blanked by S)
//   step_count number of accepted steps, wraps modulo 2^CNT_W
//   wrap       one-cycle pulse when a pattern completes a full cycle
module led_pattern_seq #(
    parameter int N_LED = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             S,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] L,
    output logic [CNT_W-1:0] step_count,
    output logic             wrap
);

    localparam logic [1:0]       MODE_BIN    = 2'd0;
    localparam logic [1:0]       MODE_WALK   = 2'd1;
    localparam logic [1:0]       MODE_BOUNCE = 2'd2;
    localparam logic [1:0]       MODE_BLINK  = 2'd3;
    localparam logic             DIR_UP      = 1'b0;
    localparam logic             DIR_DN      = 1'b1;
    localparam logic [N_LED-1:0] PAT_ZERO    = {N_LED{1'b0}};
    localparam logic [N_LED-1:0] PAT_ONE     = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] PAT_ALL     = {N_LED{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_q, s2_q, s3_q;
    logic [1:0]       arm_q, arm_d;
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic [N_LED-1:0] pat_q, pat_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic             accept_s;
    logic             one_hot_s;
    logic [N_LED-1:0] inc_s, inv_s, rotl_s, shl_s, shr_s;

    // A step is only taken once the arm counter has seen three clean cycles
    // after reset, so a tick level already high through reset is never an edge.
    assign accept_s  = s2_q & ~s3_q & (arm_q == 2'd3) & ~S;
    assign one_hot_s = (pat_q != PAT_ZERO) && ((pat_q & (pat_q - PAT_ONE)) == PAT_ZERO);
    assign inc_s     = pat_q + PAT_ONE;
    assign inv_s     = ~pat_q;
    assign rotl_s    = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
    assign shl_s     = {pat_q[N_LED-2:0], 1'b0};
    assign shr_s     = {1'b0, pat_q[N_LED-1:1]};

    // State register: synchroniser, arm counter, pattern state and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            arm_q      <= 2'd0;
            cur_mode_q <= MODE_BIN;
            pat_q      <= PAT_ZERO;
            dir_q      <= DIR_UP;
            cnt_q      <= {CNT_W{1'b0}};
            wrap_q     <= 1'b0;
        end else begin
            s1_q       <= tick;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            arm_q      <= arm_d;
            cur_mode_q <= cur_mode_d;
            pat_q      <= pat_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
        end
    end

    // Next-state: arm counter and pattern advance on accepted steps.
    always_comb begin
        arm_d      = arm_q;
        cur_mode_d = cur_mode_q;
        pat_d      = pat_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;

        if (arm_q != 2'd3) begin
            arm_d = arm_q + 2'd1;
        end else begin
            arm_d = arm_q;
        end

        if (accept_s) begin
            cnt_d = cnt_q + CNT_ONE;
            if (mode != cur_mode_q) begin
                // A mode change only loads the new pattern's start point.
                cur_mode_d = mode;
                dir_d      = DIR_UP;
                case (mode)
                    MODE_BIN:    pat_d = PAT_ZERO;
                    MODE_WALK:   pat_d = PAT_ONE;
                    MODE_BOUNCE: pat_d = PAT_ONE;
                    MODE_BLINK:  pat_d = PAT_ALL;
                    default:     pat_d = PAT_ZERO;
                endcase
            end else begin
                case (cur_mode_q)
                    MODE_BIN: begin
                        pat_d  = inc_s;
                        wrap_d = (inc_s == PAT_ZERO);
                    end
                    MODE_WALK: begin
                        if (one_hot_s) begin
                            pat_d  = rotl_s;
                            wrap_d = (rotl_s == PAT_ONE);
                        end else begin
                            pat_d  = PAT_ONE;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (!one_hot_s) begin
                            pat_d = PAT_ONE;
                            dir_d = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            pat_d = shl_s;
                            if (shl_s[N_LED-1]) begin
                                dir_d = DIR_DN;
                            end else begin
                                dir_d = DIR_UP;
                            end
                        end else begin
                            pat_d = shr_s;
                            if (shr_s == PAT_ONE) begin
                                dir_d  = DIR_UP;
                                wrap_d = 1'b1;
                            end else begin
                                dir_d  = DIR_DN;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        pat_d  = inv_s;
                        wrap_d = (inv_s == PAT_ALL);
                    end
                    default: begin
                        pat_d = PAT_ZERO;
                    end
                endcase
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs: blanking by S is combinational so it takes effect immediately.
    always_comb begin
        if (S) begin
            L = PAT_ZERO;
        end else begin
            L = pat_q;
        end
        step_count = cnt_q;
        wrap       = wrap_q;
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: two instances (N_LED=2/CNT_W=16 and
// N_LED=4/CNT_W=4) share stimulus and are compared every cycle against a
// position-based reference model of the pattern sequences.
module tb_led_pattern_seq;

    localparam int NA = 2;
    localparam int NB = 4;
    localparam int CA = 16;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          S = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [NA-1:0] l_a;
    logic [NB-1:0] l_b;
    logic [CA-1:0] cnt_a;
    logic [CB-1:0] cnt_b;
    logic          wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    // model state
    int m_cur;
    int m_pos [2];
    int m_cnt;
    int m_wrap [2];
    int m_arm;
    bit m_hist [$];
    int wraps_a, wraps_b;

    led_pattern_seq #(.N_LED(NA), .CNT_W(CA)) u_dut_a (
        .clk(clk), .reset(reset), .tick(tick), .S(S), .mode(mode),
        .L(l_a), .step_count(cnt_a), .wrap(wrap_a)
    );

    led_pattern_seq #(.N_LED(NB), .CNT_W(CB)) u_dut_b (
        .clk(clk), .reset(reset), .tick(tick), .S(S), .mode(mode),
        .L(l_b), .step_count(cnt_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int period_of(input int n, input int md);
        case (md)
            0:       return 1 << n;
            1:       return n;
            2:       return 2 * (n - 1);
            default: return 2;
        endcase
    endfunction

    // Pattern at a given position within a mode's cycle.
    function automatic int pat_of(input int n, input int md, input int pos);
        case (md)
            0:       return pos;
            1:       return 1 << pos;
            2:       return (pos < n) ? (1 << pos) : (1 << (2 * (n - 1) - pos));
            default: return (pos == 0) ? ((1 << n) - 1) : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_cur = 0;
        m_pos[0] = 0;
        m_pos[1] = 0;
        m_cnt = 0;
        m_wrap[0] = 0;
        m_wrap[1] = 0;
        m_arm = 0;
    endtask

    // Model effect of one clock edge with the currently applied inputs.
    task automatic model_edge(input bit r, input bit t, input bit s, input int md);
        int n;
        bit rise;
        m_wrap[0] = 0;
        m_wrap[1] = 0;
        if (r) begin
            model_reset();
            m_hist.push_front(1'b0);
        end else begin
            // rising edge of tick sampled two and three edges ago
            rise = m_hist[1] && !m_hist[2];
            if (rise && m_arm >= 3 && !s) begin
                m_cnt++;
                if (md != m_cur) begin
                    m_cur = md;
                    m_pos[0] = 0;
                    m_pos[1] = 0;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        n = (i == 0) ? NA : NB;
                        m_pos[i] = (m_pos[i] + 1) % period_of(n, m_cur);
                        m_wrap[i] = (m_pos[i] == 0);
                    end
                end
            end
            m_hist.push_front(t);
            if (m_arm < 3) m_arm++;
        end
        while (m_hist.size() > 4) void'(m_hist.pop_back());
    endtask

    // One clock cycle: drive, let the edge happen, then compare everything.
    task automatic cyc(input bit r, input bit t, input bit s, input int md);
        @(negedge clk);
        reset = r;
        tick = t;
        S = s;
        mode = md[1:0];
        @(posedge clk);
        model_edge(r, t, s, md);
        #1;
        check("L_a", int'(l_a), s ? 0 : pat_of(NA, m_cur, m_pos[0]));
        check("L_b", int'(l_b), s ? 0 : pat_of(NB, m_cur, m_pos[1]));
        check("cnt_a", int'(cnt_a), m_cnt % (1 << CA));
        check("cnt_b", int'(cnt_b), m_cnt % (1 << CB));
        check("wrap_a", int'(wrap_a), m_wrap[0]);
        check("wrap_b", int'(wrap_b), m_wrap[1]);
        if (wrap_a) wraps_a++;
        if (wrap_b) wraps_b++;
    endtask

    task automatic pulse(input bit s, input int md);
        cyc(0, 1, s, md);
        cyc(0, 1, s, md);
        cyc(0, 0, s, md);
        cyc(0, 0, s, md);
    endtask

    initial begin
        int saved;
        bit r, t, s;
        int md;
        model_reset();
        for (int i = 0; i < 4; i++) m_hist.push_back(1'b0);

        // reset and first-step latency
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_L", int'(l_a), 0);
        check("rst_cnt", int'(cnt_a), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("lat_k", int'(l_a), 0);
        cyc(0, 1, 0, 0);
        check("lat_k1", int'(l_a), 0);
        cyc(0, 0, 0, 0);
        check("lat_k2_L", int'(l_a), 1);
        check("lat_k2_cnt", int'(cnt_a), 1);
        cyc(0, 0, 0, 0);

        // binary count on N_LED=2
        wraps_a = 0;
        for (int i = 0; i < 4; i++) pulse(0, 0);
        check("bin_cnt", int'(cnt_a), 5);
        check("bin_L", int'(l_a), 1);
        check("bin_wraps", wraps_a, 1);

        // bounce on N_LED=4
        wraps_b = 0;
        for (int i = 0; i < 8; i++) pulse(0, 2);
        check("bnc_L", int'(l_b), 2);
        check("bnc_wraps", wraps_b, 1);

        // pause while walking
        pulse(0, 1);
        pulse(0, 1);
        check("walk_L", int'(l_b), 2);
        saved = int'(cnt_a);
        for (int i = 0; i < 3; i++) pulse(1, 1);
        check("pause_L", int'(l_b), 0);
        check("pause_cnt", int'(cnt_a), saved);
        cyc(0, 0, 0, 1);
        check("unpause_L", int'(l_b), 2);
        pulse(0, 1);
        check("walk_next", int'(l_b), 4);

        // tick held high through and after reset
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
        check("held_cnt", int'(cnt_a), 0);
        check("held_L", int'(l_a), 0);

        // mid-run reset in blink mode
        cyc(0, 0, 0, 3);
        cyc(0, 0, 0, 3);
        for (int i = 0; i < 5; i++) pulse(0, 3);
        cyc(1, 0, 0, 3);
        check("mid_L", int'(l_a), 0);
        check("mid_cnt", int'(cnt_a), 0);
        check("mid_wrap", int'(wrap_a), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        pulse(0, 0);
        check("mid_after_L", int'(l_a), 1);

        // randomized run
        t = 1'b0;
        s = 1'b0;
        md = 0;
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) t = ~t;
            if ($urandom_range(0, 15) == 0) s = ~s;
            if ($urandom_range(0, 39) == 0) md = int'($urandom_range(0, 3));
            cyc(r, t, s, md);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Downstream consumer of the slow divided clocks (clk_ms / clk_3 style outputs).
- Takes one divided-clock level signal as an asynchronous "tick", resynchronises it into the system clock domain and edge-detects it.
- On each accepted tick, advances a selectable LED pattern (binary count, walking one, bounce, blink) that drives the board LEDs.
- Replaces the raw {clk_3, clk_ms} LED mapping at top level. The S switch keeps its existing blanking behaviour.

Parameters:
- N_LED, 2, LED vector width; legal range 2..8.
- CNT_W, 16, width of the accepted-step counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  divided-clock level from the divider, asynchronous to clk; each rising edge is one step.
- S  input  1  pause/blank: 1 freezes the pattern and forces L to 0.
- mode  input  2  pattern select: 0 binary, 1 walk, 2 bounce, 3 blink.
- L  output  N_LED  LED drive.
- step_count  output  CNT_W  number of accepted steps, wraps modulo 2^CNT_W.
- wrap  output  1  one-cycle pulse when a pattern completes a full cycle.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high, and overrides every other input in the same cycle.
- Reset values:
  - sync chain s1/s2/s3 = 0
  - arm counter = 0
  - cur_mode = 0
  - pat = 0
  - dir = up
  - step_count = 0
  - wrap = 0
  - L = 0
- Synchroniser: tick → s1 → s2 (2-FF), s3 <= s2. Raw step = s2 & ~s3.
- Arming:
  - A 2-bit arm counter increments after reset and saturates at 3.
  - Steps are suppressed while arm < 3. A tick held high through reset therefore never yields a spurious step.
- Latency: tick first sampled high at clk edge k → s2 high at k+1 → pat/step_count/wrap update at edge k+2.
- Accepted step = raw step & armed & ~S. Raw steps while S=1 are dropped, not queued.
- On an accepted step with mode != cur_mode:
  - Load cur_mode <= mode and the mode's initial pattern; dir <= up.
  - The pattern does not advance. step_count increments. No wrap.
- Initial patterns:
  - binary: 0
  - walk: 0…01
  - bounce: 0…01
  - blink: all ones
- On an accepted step with mode == cur_mode:
  - binary: pat <= pat+1 modulo 2^N_LED. wrap when the result is 0.
  - walk: rotate left by 1, MSB→LSB. wrap when the result is 0…01. If pat is not one-hot (e.g. 0 after reset), load 0…01 instead, with no wrap.
  - bounce:
    - If dir=up: shift left; when the result has MSB set, dir <= down.
    - If dir=down: shift right; when the result is 0…01, dir <= up and wrap.
    - Period is 2·(N_LED−1) steps. A non-one-hot pat loads 0…01.
  - blink: pat <= ~pat. wrap when the result is all ones. pat=0 from reset → all ones, wrap.
- Mode 0 from reset (cur_mode=0, pat=0) counts 1, 2, … with no reload.
- wrap: registered, high exactly one cycle, in the cycle after the update edge.
- step_count: registered, increments by 1 per accepted step, rolls over 2^CNT_W−1 → 0.
- L = S ? 0 : pat. This path is combinational from S, so blanking is immediate. pat is held unchanged while S=1.
- mode is sampled only on accepted steps. Changes between steps have no effect until the next step.
- Reset asserted mid-operation: all state returns to reset values at the next clk edge. Any in-flight edge in the sync chain is discarded.

Test Plan:
- Reset/latency: hold tick=0, release reset, wait 4 cycles, raise tick at edge k → L=01 and step_count=1 at edge k+2; L=00 before that.
- Mode 0, N_LED=2, 4 ticks after the first (5 total) → L sequence 01, 10, 11, 00, 01; wrap pulses exactly once, on 11→00; step_count=5.
- Mode 2, N_LED=4:
  - First tick (mode change) → 0001.
  - Next 7 ticks → 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - Single wrap, at the return to 0001.
- Pause: mode 1 pattern at 0010; assert S for 3 tick edges → L=00, step_count unchanged. Deassert S → L=0010, and the next tick gives 0100.
- Held tick across reset: tick=1 constantly through and after reset for 20 cycles → no steps, step_count=0, L=00.
- Mid-run reset in mode 3 after 5 ticks → next edge: L=0, step_count=0, cur_mode=0, wrap=0; a tick rising edge 3 cycles later (arm counter saturated) yields L=01.
